// File: rtl/phy_rx_pkg.sv
// Shared state encoding and default framing parameters for the serial
// receive synchroniser (comma search, alignment and lock supervision).
package phy_rx_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } lock_state_e;

    localparam logic [7:0] DEF_COMMA      = 8'hBC;
    localparam int         DEF_LOCK_COUNT = 4;
    localparam int         DEF_MAX_GAP    = 64;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/phy_rx_comma_det.sv
// Serial-to-parallel shift register with a combinational compare of the
// incoming window (including the bit arriving this cycle) against COMMA.
module phy_rx_comma_det
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COMMA = DEF_COMMA
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] sr_next,
    output logic       match
);

    logic [7:0] r_sr;

    assign sr_next = {r_sr[6:0], data_in};
    assign match   = (sr_next == COMMA);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_sr <= '0;
        end else begin
            r_sr <= sr_next;
        end
    end

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Byte-alignment and lock FSM for a serial receiver: finds the comma,
// confirms LOCK_COUNT aligned commas, then emits data bytes until a gap timeout.
module phy_rx_sync_ctrl
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COMMA      = DEF_COMMA,
    parameter int         LOCK_COUNT = DEF_LOCK_COUNT,
    parameter int         MAX_GAP    = DEF_MAX_GAP
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       resync_req,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic [1:0] lock_state,
    output logic [2:0] phase,
    output logic [7:0] sync_loss_cnt
);

    localparam int CCW = $clog2(LOCK_COUNT + 1);
    localparam int GCW = $clog2(MAX_GAP + 1);
    localparam logic [CCW-1:0] LOCK_CNT_V = CCW'(LOCK_COUNT);
    localparam logic [GCW-1:0] MAX_GAP_V  = GCW'(MAX_GAP);
    localparam logic [CCW-1:0] ONE_C      = CCW'(1);
    localparam logic [GCW-1:0] ONE_G      = GCW'(1);

    lock_state_e    r_state, w_state_next;
    logic [2:0]     r_free_cnt;
    logic [2:0]     r_bit_cnt, w_bit_cnt_next;
    logic [CCW-1:0] r_comma_cnt, w_comma_cnt_next;
    logic [GCW-1:0] r_gap_cnt, w_gap_cnt_next;
    logic [7:0]     r_data_out, w_data_out_next;
    logic           r_valid, w_valid_next;
    logic [2:0]     r_phase, w_phase_next;
    logic [7:0]     r_sync_loss, w_sync_loss_next;

    logic [7:0]     w_sr_next;
    logic           w_match;
    logic           w_byte_evt;

    phy_rx_comma_det #(
        .COMMA (COMMA)
    ) u_comma_det (
        .clk_32f (clk_32f),
        .reset   (reset),
        .data_in (data_in),
        .sr_next (w_sr_next),
        .match   (w_match)
    );

    assign w_byte_evt = (r_bit_cnt == 3'd7);

    // NOTE: every signal gets its default before the case statement, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt + 3'd1;
        w_comma_cnt_next = r_comma_cnt;
        w_gap_cnt_next   = r_gap_cnt;
        w_data_out_next  = r_data_out;
        w_valid_next     = 1'b0;
        w_phase_next     = r_phase;
        w_sync_loss_next = r_sync_loss;

        if (resync_req) begin
            // Resync beats any byte event landing on the same cycle.
            w_state_next     = ST_SEARCH;
            w_comma_cnt_next = '0;
            w_gap_cnt_next   = '0;
        end else begin
            unique case (r_state)
                ST_SEARCH: begin
                    if (w_match) begin
                        w_bit_cnt_next   = 3'd0;
                        w_comma_cnt_next = ONE_C;
                        w_phase_next     = r_free_cnt;
                        w_state_next     = ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (w_byte_evt) begin
                        if (w_match) begin
                            w_comma_cnt_next = r_comma_cnt + ONE_C;
                            if (r_comma_cnt + ONE_C == LOCK_CNT_V) begin
                                w_state_next   = ST_LOCKED;
                                w_gap_cnt_next = '0;
                            end
                        end else begin
                            w_state_next     = ST_SEARCH;
                            w_comma_cnt_next = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_byte_evt) begin
                        if (w_match) begin
                            w_gap_cnt_next = '0;
                        end else begin
                            w_data_out_next = w_sr_next;
                            w_valid_next    = 1'b1;
                            w_gap_cnt_next  = r_gap_cnt + ONE_G;
                            if (r_gap_cnt + ONE_G == MAX_GAP_V) begin
                                w_state_next     = ST_SEARCH;
                                w_gap_cnt_next   = '0;
                                w_comma_cnt_next = '0;
                                w_sync_loss_next = sat_inc8(r_sync_loss);
                            end
                        end
                    end
                end
                default: begin
                    w_state_next = ST_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_free_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_comma_cnt <= '0;
            r_gap_cnt   <= '0;
            r_data_out  <= '0;
            r_valid     <= 1'b0;
            r_phase     <= '0;
            r_sync_loss <= '0;
        end else begin
            r_free_cnt  <= r_free_cnt + 3'd1;
            r_bit_cnt   <= w_bit_cnt_next;
            r_comma_cnt <= w_comma_cnt_next;
            r_gap_cnt   <= w_gap_cnt_next;
            r_data_out  <= w_data_out_next;
            r_valid     <= w_valid_next;
            r_phase     <= w_phase_next;
            r_sync_loss <= w_sync_loss_next;
        end
    end

    assign data_out      = r_data_out;
    assign valid_out     = r_valid;
    assign active        = (r_state == ST_LOCKED);
    assign lock_state    = r_state;
    assign phase         = r_phase;
    assign sync_loss_cnt = r_sync_loss;

endmodule

// File: doc/phy_rx_sync_ctrl.md
PHY_RX_SYNC_CTRL -- requirements
Module: phy_rx_sync_ctrl

Interface
REQ-001 Parameter COMMA, default 8'hBC: alignment/idle symbol.
REQ-002 Parameter LOCK_COUNT, default 4: consecutive aligned commas required to lock.
REQ-003 Parameter MAX_GAP, default 64: consecutive non-comma bytes tolerated while locked.
REQ-004 clk_32f  input  1: bit-rate clock, sole clock; all logic on rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 data_in  input  1: serial bit, MSB of each byte first.
REQ-007 resync_req  input  1: single-cycle request to drop lock and re-search.
REQ-008 data_out  output  8: last received data byte.
REQ-009 valid_out  output  1: one-cycle strobe, data_out holds a new data byte.
REQ-010 active  output  1: high while in LOCKED.
REQ-011 lock_state  output  2: 0 SEARCH, 1 ALIGN, 2 LOCKED.
REQ-012 phase  output  3: free-running bit-counter value captured at the last comma match in SEARCH.
REQ-013 sync_loss_cnt  output  8: saturating count of timeout-induced lock losses.

Function
REQ-014 Shift register SHALL update every cycle: sr_next = {sr[6:0], data_in}; all comparisons use sr_next.
REQ-015 A free-running 3-bit counter SHALL increment every cycle, wrapping 7->0.
REQ-016 Byte counter bit_cnt (0..7) SHALL produce a byte event when bit_cnt==7; the byte value is sr_next.
REQ-017 SEARCH: each cycle, when sr_next==COMMA, bit_cnt SHALL load 0, comma_cnt SHALL load 1, phase SHALL capture the free-running count, and state SHALL go to ALIGN.
REQ-018 ALIGN: on a byte event with byte==COMMA, comma_cnt SHALL increment. On reaching LOCK_COUNT, state SHALL go to LOCKED and active SHALL rise in the same update.
REQ-019 ALIGN: on a byte event with byte!=COMMA, state SHALL return to SEARCH and comma_cnt SHALL clear.
REQ-020 LOCKED, byte event, byte==COMMA: valid_out SHALL be 0, data_out SHALL be unchanged, and gap_cnt SHALL clear.
REQ-021 LOCKED, byte event, byte!=COMMA: data_out SHALL equal the byte and valid_out SHALL be 1 for exactly one cycle, registered one cycle after the eighth bit. gap_cnt SHALL increment.
REQ-022 LOCKED: when gap_cnt reaches MAX_GAP, state SHALL go to SEARCH, active SHALL fall, and sync_loss_cnt SHALL increment, saturating at 255.
REQ-023 The final byte that causes the timeout SHALL still be output with valid_out=1.
REQ-024 resync_req SHALL force SEARCH on the next edge from any state and clear comma_cnt, gap_cnt and active; sync_loss_cnt SHALL be unchanged.
REQ-025 resync_req coincident with a byte event SHALL take priority: no valid_out and no state advance.
REQ-026 In SEARCH and ALIGN, valid_out SHALL be 0.
REQ-027 Comma matches at non-boundary offsets while in ALIGN or LOCKED SHALL be ignored.

Reset
REQ-028 reset SHALL have priority over resync_req.
REQ-029 On reset: sr, bit_cnt, free-running counter, comma_cnt, gap_cnt, data_out, valid_out, active, phase and sync_loss_cnt SHALL be 0, and lock_state SHALL be SEARCH.
REQ-030 reset asserted mid-byte or while LOCKED SHALL discard the partial byte, with no valid_out on the following cycle.

Structure
REQ-031 Package phy_rx_pkg SHALL hold the state encoding (SEARCH/ALIGN/LOCKED) and the COMMA, LOCK_COUNT and MAX_GAP defaults.
REQ-032 One sub-module, phy_rx_comma_det, SHALL contain the shift register and comma compare, outputting sr_next and match.
REQ-033 The FSM and counters SHALL reside in phy_rx_sync_ctrl.

Verification
REQ-034 Four 0xBC bytes at bit offset 3, then 0x5A -> lock_state 2, active=1, phase=3, one valid_out with data_out=0x5A.
REQ-035 Three 0xBC then 0x11 -> return to SEARCH; no valid_out; active stays 0.
REQ-036 Locked, then 64 consecutive 0x33 bytes -> 64 valid_out strobes, then SEARCH, active=0, sync_loss_cnt=1.
REQ-037 Locked, with resync_req pulsed on a byte-event cycle -> no valid_out for that byte, SEARCH next cycle, sync_loss_cnt unchanged.
REQ-038 Locked, with reset asserted at bit 4 of byte 0x7E -> all outputs 0 next cycle; relock requires 4 new commas.
REQ-039 Force 256 timeouts -> sync_loss_cnt saturates at 255.
